// File: rtl/apple_motion.sv
// apple_motion: per-apple motion controller feeding the apple sprite renderer.
// Holds the apple position, launches it once when the kid enters the trigger
// window, retires it once it has fully left the screen, and flags kid/apple
// box overlap for the death logic.
// Optional feature: define APPLE_RESPAWN_EN to re-arm the apple RESPAWN_TICKS
// update ticks after it has gone off-screen.
module apple_motion #(
    parameter int INIT_X        = 0,
    parameter int INIT_Y        = 0,
    parameter int TRIG_AXIS     = 0,
    parameter int TRIG_MARGIN   = 0,
    parameter int MOVE_DIR      = 1,
    parameter int STEP          = 4,
    parameter int APPLE_W       = 22,
    parameter int APPLE_H       = 24,
    parameter int KID_W         = 11,
    parameter int KID_H         = 21,
    parameter int SCREEN_W      = 800,
    parameter int SCREEN_H      = 600,
    parameter int RESPAWN_TICKS = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       update_tick,
    input  logic [9:0] kid_x,
    input  logic [9:0] kid_y,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       visible,
    output logic       moving,
    output logic       hit
);

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        MOVING = 2'd1,
        GONE   = 2'd2
    } state_t;

    // Every geometric quantity lives in signed 12 bits so the apple can sit
    // partly above or left of the screen without wrapping.
    localparam logic signed [11:0] S_INIT_X   = 12'(INIT_X);
    localparam logic signed [11:0] S_INIT_Y   = 12'(INIT_Y);
    localparam logic signed [11:0] S_MARGIN   = 12'(TRIG_MARGIN);
    localparam logic signed [11:0] S_STEP     = 12'(STEP);
    localparam logic signed [11:0] S_APPLE_W  = 12'(APPLE_W);
    localparam logic signed [11:0] S_APPLE_H  = 12'(APPLE_H);
    localparam logic signed [11:0] S_KID_W    = 12'(KID_W);
    localparam logic signed [11:0] S_KID_H    = 12'(KID_H);
    localparam logic signed [11:0] S_SCREEN_W = 12'(SCREEN_W);
    localparam logic signed [11:0] S_SCREEN_H = 12'(SCREEN_H);
    localparam logic signed [11:0] S_ZERO     = 12'sd0;

    // Step vector chosen once from the fixed launch direction.
    localparam logic signed [11:0] S_DX = (MOVE_DIR == 2) ? -S_STEP :
                                          (MOVE_DIR == 3) ?  S_STEP : S_ZERO;
    localparam logic signed [11:0] S_DY = (MOVE_DIR == 0) ? -S_STEP :
                                          (MOVE_DIR == 1) ?  S_STEP : S_ZERO;

    // Reject configurations whose step could wrap the 12-bit position.
    if (STEP < 1 || STEP > 15 || RESPAWN_TICKS < 1) begin : g_bad_config
        $error("apple_motion: STEP must be 1..15 and RESPAWN_TICKS at least 1");
    end

`ifdef APPLE_RESPAWN_EN
    localparam int CNT_W = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESPAWN_TICKS - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    state_t             state_q, state_d;
    logic signed [11:0] px_q, px_d;
    logic signed [11:0] py_q, py_d;
    logic               visible_q, visible_d;
    logic               moving_q, moving_d;
    logic               hit_q, hit_d;

    logic signed [11:0] kid_xs, kid_ys;
    logic signed [11:0] px_step, py_step;
    logic               trig_hit;
    logic               off_screen;
    logic               overlap;

    // Kid coordinates are unsigned screen pixels; widen them for signed math.
    assign kid_xs = $signed({2'b00, kid_x});
    assign kid_ys = $signed({2'b00, kid_y});

    // Geometry: trigger window, candidate next position, off-screen test and
    // the strict box overlap used for the collision flag.
    always_comb begin
        trig_hit = 1'b0;
        if (TRIG_AXIS == 0) begin
            trig_hit = ((kid_xs + S_KID_W) > (px_q - S_MARGIN)) &&
                       (kid_xs < (px_q + S_APPLE_W + S_MARGIN));
        end else begin
            trig_hit = ((kid_ys + S_KID_H) > (py_q - S_MARGIN)) &&
                       (kid_ys < (py_q + S_APPLE_H + S_MARGIN));
        end

        px_step = px_q + S_DX;
        py_step = py_q + S_DY;

        off_screen = ((py_step + S_APPLE_H) <= S_ZERO) ||
                     (py_step >= S_SCREEN_H)           ||
                     ((px_step + S_APPLE_W) <= S_ZERO) ||
                     (px_step >= S_SCREEN_W);

        overlap = (kid_xs < (px_q + S_APPLE_W)) &&
                  ((kid_xs + S_KID_W) > px_q)   &&
                  (kid_ys < (py_q + S_APPLE_H)) &&
                  ((kid_ys + S_KID_H) > py_q);
    end

    // Next-state logic: one-shot launch, stepping, retirement and optional
    // re-arm; visible/moving are computed alongside so they change with state.
    always_comb begin
        state_d   = state_q;
        px_d      = px_q;
        py_d      = py_q;
        visible_d = visible_q;
        moving_d  = moving_q;
`ifdef APPLE_RESPAWN_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ARMED: begin
                if (update_tick && trig_hit) begin
                    state_d  = MOVING;
                    moving_d = 1'b1;
                end
            end
            MOVING: begin
                if (update_tick) begin
                    px_d = px_step;
                    py_d = py_step;
                    if (off_screen) begin
                        state_d   = GONE;
                        visible_d = 1'b0;
                        moving_d  = 1'b0;
                    end
                end
            end
            GONE: begin
`ifdef APPLE_RESPAWN_EN
                if (update_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        px_d      = S_INIT_X;
                        py_d      = S_INIT_Y;
                        state_d   = ARMED;
                        visible_d = 1'b1;
                        moving_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`else
                state_d = GONE;
`endif
            end
            default: begin
                state_d   = ARMED;
                px_d      = S_INIT_X;
                py_d      = S_INIT_Y;
                visible_d = 1'b1;
                moving_d  = 1'b0;
            end
        endcase

        hit_d = overlap && (state_q != GONE);
    end

    // State and output registers; reset has priority over any tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARMED;
            px_q      <= S_INIT_X;
            py_q      <= S_INIT_Y;
            visible_q <= 1'b1;
            moving_q  <= 1'b0;
            hit_q     <= 1'b0;
`ifdef APPLE_RESPAWN_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            px_q      <= px_d;
            py_q      <= py_d;
            visible_q <= visible_d;
            moving_q  <= moving_d;
            hit_q     <= hit_d;
`ifdef APPLE_RESPAWN_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign pos_x   = px_q[9:0];
    assign pos_y   = py_q[9:0];
    assign visible = visible_q;
    assign moving  = moving_q;
    assign hit     = hit_q;

endmodule
